// File: rtl/freq_latch_bank_if.sv
// Bus between the gate controller / display side and freq_latch_bank.
// PEAK_HOLD_EN adds peak_clr and d_peak to the bundle.
interface freq_latch_bank_if #(
   parameter int DIGITS = 8,
   parameter int DEPTH  = 4
);
   localparam int W  = 4*DIGITS;
   localparam int IW = $clog2(DEPTH);

   logic          latch_en;
   logic          hold;
   logic          ovf_in;
   logic [W-1:0]  q;
   logic [IW-1:0] rd_idx;
   logic [W-1:0]  d;
   logic [W-1:0]  d_hist;
   logic [DIGITS-1:0] blank_mask;
   logic          new_pulse;
   logic          ovf_flag;
   logic          bcd_err;
   logic [IW:0]   hist_cnt;
   logic [7:0]    drop_cnt;
`ifdef PEAK_HOLD_EN
   logic          peak_clr;
   logic [W-1:0]  d_peak;

   modport master (
      output latch_en, hold, ovf_in, q, rd_idx, peak_clr,
      input  d, d_hist, blank_mask, new_pulse, ovf_flag, bcd_err, hist_cnt, drop_cnt, d_peak
   );
   modport slave (
      input  latch_en, hold, ovf_in, q, rd_idx, peak_clr,
      output d, d_hist, blank_mask, new_pulse, ovf_flag, bcd_err, hist_cnt, drop_cnt, d_peak
   );
`else
   modport master (
      output latch_en, hold, ovf_in, q, rd_idx,
      input  d, d_hist, blank_mask, new_pulse, ovf_flag, bcd_err, hist_cnt, drop_cnt
   );
   modport slave (
      input  latch_en, hold, ovf_in, q, rd_idx,
      output d, d_hist, blank_mask, new_pulse, ovf_flag, bcd_err, hist_cnt, drop_cnt
   );
`endif
endinterface

// File: rtl/freq_latch_bank.sv
// Result latch for the frequency meter: validates BCD counts, holds them for the
// display and keeps a history ring. Optional PEAK_HOLD_EN adds a clearable peak register.
module freq_latch_bank #(
   parameter int DIGITS = 8,
   parameter int DEPTH  = 4
) (
   input  logic             clk_1Hz,
   input  logic             rst,
   freq_latch_bank_if.slave bus
);
   localparam int W  = 4*DIGITS;
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [W-1:0]      ring [DEPTH];
   logic [IW-1:0]     wr_ptr;
   logic [IW-1:0]     rd_ptr;
   logic [W-1:0]      d_r;
   logic              ovf_r;
   logic              err_r;
   logic              pulse_r;
   logic [CW-1:0]     hist_cnt;
   logic [7:0]        drop_r;
   logic              q_valid;
   logic              strobe;
   logic              accept;
   logic              run;
   logic [DIGITS-1:0] blank;

   always_comb begin
      q_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.q[4*i +: 4] > 4'd9) q_valid = 1'b0;
      end
   end

   assign strobe = bus.latch_en & ~bus.hold;
   assign accept = strobe & q_valid;

   always_ff @(posedge clk_1Hz or posedge rst) begin
      if (rst) begin
         d_r      <= '0;
         ovf_r    <= 1'b0;
         err_r    <= 1'b0;
         pulse_r  <= 1'b0;
         hist_cnt <= '0;
         drop_r   <= '0;
         wr_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      end else begin
         pulse_r <= accept;
         if (accept) begin
            d_r          <= bus.q;
            ovf_r        <= bus.ovf_in;
            err_r        <= 1'b0;
            ring[wr_ptr] <= bus.q;
            wr_ptr       <= wr_ptr + IW'(1);
            if (hist_cnt != CW'(DEPTH)) hist_cnt <= hist_cnt + CW'(1);
         end else if (strobe) begin
            err_r <= 1'b1;
         end
         if (bus.latch_en && bus.hold && drop_r != 8'hFF) drop_r <= drop_r + 8'd1;
      end
   end

   // rd_idx 0 is the newest entry, one behind the write pointer
   assign rd_ptr = wr_ptr - IW'(1) - bus.rd_idx;

   // Leading-zero scan from the most significant digit; digit 0 always stays lit
   always_comb begin
      blank = '0;
      run   = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         run      = run & (d_r[4*i +: 4] == 4'd0);
         blank[i] = run;
      end
      blank[0] = 1'b0;
   end

   assign bus.d          = d_r;
   assign bus.d_hist     = ({1'b0, bus.rd_idx} < hist_cnt) ? ring[rd_ptr] : '0;
   assign bus.blank_mask = blank;
   assign bus.new_pulse  = pulse_r;
   assign bus.ovf_flag   = ovf_r;
   assign bus.bcd_err    = err_r;
   assign bus.hist_cnt   = hist_cnt;
   assign bus.drop_cnt   = drop_r;

`ifdef PEAK_HOLD_EN
   logic [W-1:0] peak_r;

   // Packed BCD orders the same as plain unsigned binary, MSD first
   always_ff @(posedge clk_1Hz or posedge rst) begin
      if (rst) begin
         peak_r <= '0;
      end else if (bus.peak_clr) begin
         peak_r <= '0;
      end else if (accept && bus.q > peak_r) begin
         peak_r <= bus.q;
      end
   end

   assign bus.d_peak = peak_r;
`endif
endmodule

// File: tb/tb_freq_latch_bank.sv
// Self-checking bench for freq_latch_bank: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_freq_latch_bank;
   localparam int DIGITS = 8;
   localparam int DEPTH  = 4;
   localparam int W      = 4*DIGITS;

   logic clk_1Hz = 1'b0;
   logic rst     = 1'b1;
   logic peak_clr_tb = 1'b0;
   int   checks = 0;
   int   errors = 0;

   freq_latch_bank_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bif ();

   freq_latch_bank #(.DIGITS(DIGITS), .DEPTH(DEPTH)) dut (
      .clk_1Hz (clk_1Hz),
      .rst     (rst),
      .bus     (bif)
   );

`ifdef PEAK_HOLD_EN
   assign bif.peak_clr = peak_clr_tb;
`endif

   always #5 clk_1Hz = ~clk_1Hz;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   // reference model state
   logic [W-1:0] m_d, m_peak;
   logic         m_ovf, m_err, m_pulse;
   int           m_drop;
   logic [W-1:0] m_hist[$];

   typedef struct {
      logic         le;
      logic         hold;
      logic [W-1:0] q;
      logic [W-1:0] exp_d;
      logic         exp_err;
      logic         exp_pulse;
      logic [7:0]   exp_blank;
   } vec_t;

   vec_t vt[11];

   function automatic bit is_bcd(input logic [W-1:0] v);
      longint unsigned x = longint'(v);
      for (int i = 0; i < DIGITS; i++) begin
         if ((x / (64'd1 << (4*i))) % 16 > 9) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [DIGITS-1:0] exp_blank(input logic [W-1:0] v);
      logic [DIGITS-1:0] b;
      longint unsigned x = longint'(v);
      for (int i = 0; i < DIGITS; i++) b[i] = ((x / (64'd1 << (4*i))) == 0);
      b[0] = 1'b0;
      return b;
   endfunction

   function automatic logic [W-1:0] exp_hist(input int idx);
      if (idx < m_hist.size()) return m_hist[idx];
      return '0;
   endfunction

   task automatic model_reset();
      m_d = '0; m_peak = '0; m_ovf = 0; m_err = 0; m_pulse = 0; m_drop = 0;
      m_hist.delete();
   endtask

   task automatic model_edge(input logic le, input logic hold, input logic ovf,
                             input logic [W-1:0] q, input logic pclr);
      bit acc;
      acc = le && !hold && is_bcd(q);
      m_pulse = acc;
      if (le && hold && m_drop < 255) m_drop++;
      if (le && !hold && !acc) m_err = 1'b1;
      if (acc) begin
         m_d = q; m_ovf = ovf; m_err = 1'b0;
         m_hist.push_front(q);
         if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
      end
      if (pclr) m_peak = '0;
      else if (acc && q > m_peak) m_peak = q;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("d", 64'(bif.d), 64'(m_d));
      chk("d_hist", 64'(bif.d_hist), 64'(exp_hist(int'(bif.rd_idx))));
      chk("blank_mask", 64'(bif.blank_mask), 64'(exp_blank(m_d)));
      chk("new_pulse", 64'(bif.new_pulse), 64'(m_pulse));
      chk("ovf_flag", 64'(bif.ovf_flag), 64'(m_ovf));
      chk("bcd_err", 64'(bif.bcd_err), 64'(m_err));
      chk("hist_cnt", 64'(bif.hist_cnt), 64'(m_hist.size()));
      chk("drop_cnt", 64'(bif.drop_cnt), 64'(m_drop));
`ifdef PEAK_HOLD_EN
      chk("d_peak", 64'(bif.d_peak), 64'(m_peak));
`endif
   endtask

   // one clock edge; outputs are stable 1 time unit later
   task automatic tick();
      logic le, hd, ov, pc;
      logic [W-1:0] qq;
      le = bif.latch_en; hd = bif.hold; ov = bif.ovf_in; qq = bif.q;
`ifdef PEAK_HOLD_EN
      pc = peak_clr_tb;
`else
      pc = 1'b0;
`endif
      @(posedge clk_1Hz);
      if (rst) model_reset();
      else model_edge(le, hd, ov, qq, pc);
      #1;
   endtask

   task automatic drive(input logic le, input logic hd, input logic ov, input logic [W-1:0] qq);
      bif.latch_en = le; bif.hold = hd; bif.ovf_in = ov; bif.q = qq;
   endtask

   task automatic do_reset();
      @(negedge clk_1Hz);
      drive(0, 0, 0, '0);
      bif.rd_idx = '0;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk_1Hz);
      rst = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v = '0;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      vt[0]  = '{1'b1, 1'b0, 32'h0012_3456, 32'h0012_3456, 1'b0, 1'b1, 8'hC0};
      vt[1]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0012_3456, 1'b0, 1'b0, 8'hC0};
      vt[2]  = '{1'b1, 1'b0, 32'h0000_00A1, 32'h0012_3456, 1'b1, 1'b0, 8'hC0};
      vt[3]  = '{1'b1, 1'b0, 32'h0000_0099, 32'h0000_0099, 1'b0, 1'b1, 8'hFC};
      vt[4]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0099, 1'b0, 1'b0, 8'hFC};
      vt[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 8'hFE};
      vt[6]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 8'h00};
      vt[7]  = '{1'b1, 1'b0, 32'h9000_0000, 32'h9000_0000, 1'b0, 1'b1, 8'h00};
      vt[8]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b1, 8'hFC};
      vt[9]  = '{1'b1, 1'b0, 32'hF000_0000, 32'h0000_0010, 1'b1, 1'b0, 8'hFC};
      vt[10] = '{1'b1, 1'b1, 32'h0000_0009, 32'h0000_0010, 1'b1, 1'b0, 8'hFC};

      drive(0, 0, 0, '0);
      bif.rd_idx = '0;
      rst = 1'b1;
      model_reset();
      #3;
      compare_all();
      chk("reset blank_mask", 64'(bif.blank_mask), 64'h00FE);
      @(negedge clk_1Hz);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(vt[i].le, vt[i].hold, 1'b0, vt[i].q);
         tick();
         chk($sformatf("tbl%0d d", i), 64'(bif.d), 64'(vt[i].exp_d));
         chk($sformatf("tbl%0d bcd_err", i), 64'(bif.bcd_err), 64'(vt[i].exp_err));
         chk($sformatf("tbl%0d new_pulse", i), 64'(bif.new_pulse), 64'(vt[i].exp_pulse));
         chk($sformatf("tbl%0d blank_mask", i), 64'(bif.blank_mask), 64'(vt[i].exp_blank));
         compare_all();
      end
      drive(0, 0, 0, '0);

      // hold suppresses capture and counts dropped strobes
      do_reset();
      drive(1, 1, 0, 32'h0000_0777);
      repeat (3) tick();
      chk("hold d frozen", 64'(bif.d), 64'h0);
      chk("hold drop_cnt", 64'(bif.drop_cnt), 64'd3);
      drive(1, 0, 0, 32'h0000_0777);
      tick();
      chk("resume d", 64'(bif.d), 64'h777);
      chk("resume pulse", 64'(bif.new_pulse), 64'd1);
      drive(0, 0, 0, '0);
      tick();
      chk("pulse one cycle", 64'(bif.new_pulse), 64'd0);
      compare_all();

      // history ring wraps after DEPTH captures
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         drive(1, 0, 0, W'(k));
         tick();
      end
      drive(0, 0, 0, '0);
      for (int r = 0; r < DEPTH; r++) begin
         @(negedge clk_1Hz);
         bif.rd_idx = 2'(r);
         #1;
         chk($sformatf("hist rd_idx %0d", r), 64'(bif.d_hist), 64'(5 - r));
      end
      chk("hist_cnt sat", 64'(bif.hist_cnt), 64'd4);
      bif.rd_idx = '0;
      tick();
      compare_all();

      // entries beyond hist_cnt read as zero
      do_reset();
      drive(1, 0, 0, 32'h0000_0007);
      tick();
      drive(0, 0, 0, '0);
      bif.rd_idx = 2'd1;
      #1;
      chk("hist beyond cnt", 64'(bif.d_hist), 64'h0);
      bif.rd_idx = 2'd0;
      #1;
      chk("hist newest", 64'(bif.d_hist), 64'h7);
      tick();
      compare_all();

      // overflow capture, then asynchronous reset mid-run
      drive(1, 0, 1, 32'h0000_4321);
      tick();
      chk("ovf_flag set", 64'(bif.ovf_flag), 64'd1);
      drive(1, 1, 0, 32'h0000_0001);
      tick();
      drive(0, 0, 0, '0);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("async rst d", 64'(bif.d), 64'h0);
      chk("async rst blank", 64'(bif.blank_mask), 64'h00FE);
      chk("async rst drop", 64'(bif.drop_cnt), 64'h0);
      compare_all();
      @(negedge clk_1Hz);
      rst = 1'b0;
      drive(1, 0, 0, 32'h0000_0055);
      tick();
      chk("post-rst capture", 64'(bif.d), 64'h55);
      chk("post-rst hist_cnt", 64'(bif.hist_cnt), 64'd1);
      compare_all();

      // drop counter saturation
      drive(1, 1, 0, '0);
      repeat (260) tick();
      chk("drop_cnt sat", 64'(bif.drop_cnt), 64'd255);
      drive(0, 0, 0, '0);

`ifdef PEAK_HOLD_EN
      do_reset();
      drive(1, 0, 0, 32'h50); tick();
      drive(1, 0, 0, 32'h90); tick();
      drive(1, 0, 0, 32'h20); tick();
      chk("peak 90", 64'(bif.d_peak), 64'h90);
      peak_clr_tb = 1'b1;
      drive(1, 0, 0, 32'h30); tick();
      peak_clr_tb = 1'b0;
      chk("peak_clr priority", 64'(bif.d_peak), 64'h0);
      chk("peak_clr capture d", 64'(bif.d), 64'h30);
      compare_all();
      drive(0, 0, 0, '0);
`endif

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 20),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 80) ? rand_bcd() : W'($urandom()));
         bif.rd_idx = 2'($urandom_range(0, DEPTH-1));
         peak_clr_tb = ($urandom_range(0, 99) < 5);
         tick();
         compare_all();
      end
      peak_clr_tb = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
